// File: rtl/seq_mul_param_if.sv
// Handshake/operand bundle for the sequential multiplier: the requester drives
// start/sgn/A/B, the multiplier returns O/busy/done.
interface seq_mul_param_if #(
  parameter int W = 8
);
  logic             start;
  logic             sgn;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [2*W-1:0]   O;
  logic             busy;
  logic             done;

  modport master (
    output start, sgn, A, B,
    input  O, busy, done
  );

  modport slave (
    input  start, sgn, A, B,
    output O, busy, done
  );
endinterface

// File: rtl/seq_mul_param.sv
// Parametrised shift-add multiplier: W-bit operands, 2W-bit product, optional
// two's-complement mode; one product every W+2 cycles via IDLE -> CALC -> FIX.
module seq_mul_param #(
  parameter int W         = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic           ck,
  input  logic           rst_n,
  seq_mul_param_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2*W:0]     acc_q, acc_d;
  logic [W-1:0]     mag_a_q, mag_a_d;
  logic [W-1:0]     mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   o_q, o_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sgn_eff;
  logic [W:0]       acc_hi_sum;
  logic [2*W:0]     acc_sum;

  assign sgn_eff = SIGNED_EN & bus.sgn;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    o_d        = o_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    acc_hi_sum = '0;
    acc_sum    = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Magnitudes are W-bit unsigned; -2^(W-1) negates to itself, which
          // is the correct unsigned magnitude.
          mag_a_d = (sgn_eff && bus.A[W-1]) ? -bus.A : bus.A;
          mag_b_d = (sgn_eff && bus.B[W-1]) ? -bus.B : bus.B;
          neg_d   = sgn_eff & (bus.A[W-1] ^ bus.B[W-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end

      CALC: begin
        // Upper W+1 bits take the conditional add with carry; the whole
        // {acc, mag_b} chain then shifts right so the next multiplier bit lands in bit 0.
        acc_hi_sum         = acc_q[2*W:W] + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
        acc_sum            = {acc_hi_sum, acc_q[W-1:0]};
        {acc_d, mag_b_d}   = {acc_sum, mag_b_q} >> 1;
        cnt_d              = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        o_d     = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.O    = o_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed-vector bench for seq_mul_param: a W=8 signed-capable instance and a
// W=16 unsigned-only instance sharing clock and reset.
module tb_seq_mul_param;

  logic ck;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  seq_mul_param_if #(.W(8))  b8 ();
  seq_mul_param_if #(.W(16)) b16 ();

  seq_mul_param #(.W(8), .SIGNED_EN(1'b1)) u_mul8 (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (b8)
  );

  seq_mul_param #(.W(16), .SIGNED_EN(1'b0)) u_mul16 (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (b16)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one op on the 8-bit unit; returns at the negedge of the done cycle.
  // lat counts edges from the accept edge up to the one that raised done.
  task automatic do_op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] res, output int lat, output int bcnt);
    @(negedge ck);
    b8.start = 1'b1; b8.sgn = s; b8.A = a; b8.B = b;
    @(negedge ck);
    b8.start = 1'b0;
    lat = 1; bcnt = 0;
    while (!b8.done && lat < 40) begin
      if (b8.busy) bcnt++;
      @(negedge ck);
      lat++;
    end
    res = b8.O;
  endtask

  task automatic do_op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] res, output int lat);
    @(negedge ck);
    b16.start = 1'b1; b16.sgn = s; b16.A = a; b16.B = b;
    @(negedge ck);
    b16.start = 1'b0;
    lat = 1;
    while (!b16.done && lat < 60) begin
      @(negedge ck);
      lat++;
    end
    res = b16.O;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    logic [15:0] r8;
    logic [31:0] r16;
    logic [15:0] e8;
    logic [31:0] e16;
    logic signed [15:0] sp;
    logic        rs;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    int          lat, bcnt, ndone;
    int          dcyc[3];
    logic [15:0] dval[3];

    vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    vecs[3]  = '{1'b1, 8'hFD, 8'h07, 16'hFFEB};
    vecs[4]  = '{1'b1, 8'h00, 8'hFB, 16'h0000};
    vecs[5]  = '{1'b0, 8'hC8, 8'h64, 16'h4E20};
    vecs[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[8]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
    vecs[9]  = '{1'b1, 8'h7F, 8'h81, 16'hC0FF};
    vecs[10] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vecs[12] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};

    rst_n = 1'b0;
    b8.start = 1'b0;  b8.sgn = 1'b0;  b8.A = '0;  b8.B = '0;
    b16.start = 1'b0; b16.sgn = 1'b0; b16.A = '0; b16.B = '0;
    #1;
    check("reset_O",    64'(b8.O),    64'h0);
    check("reset_busy", 64'(b8.busy), 64'h0);
    check("reset_done", 64'(b8.done), 64'h0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;

    // 255*255 unsigned: latency, busy width and single-cycle done.
    do_op8(1'b0, 8'hFF, 8'hFF, r8, lat, bcnt);
    check("t1_O",       64'(r8),   64'hFE01);
    check("t1_latency", 64'(lat),  64'd10);
    check("t1_busy",    64'(bcnt), 64'd9);
    @(negedge ck);
    check("t1_done_pulse", 64'(b8.done), 64'h0);
    check("t1_O_held",     64'(b8.O),    64'hFE01);

    for (int i = 0; i < 13; i++) begin
      do_op8(vecs[i].s, vecs[i].a, vecs[i].b, r8, lat, bcnt);
      check($sformatf("vec%0d_O", i),   64'(r8),  64'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd10);
    end

    // start held high; operands changed mid-CALC must not disturb results.
    @(negedge ck);
    b8.start = 1'b1; b8.sgn = 1'b0; b8.A = 8'd3; b8.B = 8'd5;
    ndone = 0;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(negedge ck);
      if (cyc == 4)  begin b8.A = 8'd100; b8.B = 8'd2; end
      if (cyc == 14) begin b8.A = 8'd7;   b8.B = 8'd6; end
      if (cyc == 15) check("t4_O_hold", 64'(b8.O), 64'd15);
      if (b8.done) begin
        if (ndone < 3) begin
          dcyc[ndone] = cyc;
          dval[ndone] = b8.O;
        end
        ndone++;
      end
      if (cyc == 30) b8.start = 1'b0;
    end
    check("t4_ndone", 64'(ndone), 64'd3);
    if (ndone >= 3) begin
      check("t4_done0_cyc", 64'(dcyc[0]), 64'd10);
      check("t4_done1_cyc", 64'(dcyc[1]), 64'd20);
      check("t4_done2_cyc", 64'(dcyc[2]), 64'd30);
      check("t4_res0", 64'(dval[0]), 64'd15);
      check("t4_res1", 64'(dval[1]), 64'd200);
      check("t4_res2", 64'(dval[2]), 64'd42);
    end
    check("t4_idle_busy", 64'(b8.busy), 64'h0);

    // Reset in the middle of 200*100 aborts without a done pulse.
    @(negedge ck);
    b8.start = 1'b1; b8.sgn = 1'b0; b8.A = 8'd200; b8.B = 8'd100;
    @(negedge ck);
    b8.start = 1'b0;
    repeat (4) @(negedge ck);
    rst_n = 1'b0;
    #1;
    check("t5_rst_O",    64'(b8.O),    64'h0);
    check("t5_rst_busy", 64'(b8.busy), 64'h0);
    check("t5_rst_done", 64'(b8.done), 64'h0);
    @(negedge ck);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge ck);
      if (b8.done) ndone++;
    end
    check("t5_no_done", 64'(ndone),   64'd0);
    check("t5_O_after", 64'(b8.O),    64'h0);
    do_op8(1'b0, 8'd200, 8'd100, r8, lat, bcnt);
    check("t5_restart", 64'(r8), 64'd20000);

    // W=16 unit has signed mode disabled: sgn must be ignored.
    do_op16(1'b1, 16'hFFFF, 16'h0002, r16, lat);
    check("t6_O",   64'(r16), 64'h0001FFFE);
    check("t6_lat", 64'(lat), 64'd18);
    do_op16(1'b1, 16'hFFFF, 16'hFFFF, r16, lat);
    check("t6_max", 64'(r16), 64'hFFFE0001);

    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (rs) begin
        sp = $signed(ra) * $signed(rb);
        e8 = sp;
      end else begin
        e8 = 16'(ra) * 16'(rb);
      end
      do_op8(rs, ra, rb, r8, lat, bcnt);
      check($sformatf("rnd8_%0d_%0h_%0h_s%0d", i, ra, rb, rs), 64'(r8), 64'(e8));
    end

    for (int i = 0; i < 100; i++) begin
      rs   = 1'($urandom_range(0, 1));
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      e16  = 32'(ra16) * 32'(rb16);
      do_op16(rs, ra16, rb16, r16, lat);
      check($sformatf("rnd16_%0d_%0h_%0h", i, ra16, rb16), 64'(r16), 64'(e16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
